// File: rtl/ldpc_3gpp_enc_p1_acc_pkg.sv
// ============================================================================
// Module   : ldpc_3gpp_enc_p1_acc_pkg
// Brief    : Shared types and constants for the p1 feeder accumulator.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ldpc_3gpp_enc_p1_acc_pkg;

    localparam int cENC_CORE_ROWS = 4;
    localparam int c_DAT_W        = 8;
    localparam int c_ZC_W         = 9;

    typedef logic [c_DAT_W-1:0] dat_t;
    typedef logic [c_ZC_W-1:0]  hb_zc_t;

    typedef enum logic [1:0] {
        c_ACC_IDLE  = 2'd0,
        c_ACC_ACC   = 2'd1,
        c_ACC_FLUSH = 2'd2,
        c_ACC_DRAIN = 2'd3
    } enc_acc_state_t;

endpackage

`default_nettype wire

// File: rtl/ldpc_3gpp_enc_p1_acc_ram.sv
// ============================================================================
// Module   : ldpc_3gpp_enc_acc_ram
// Brief    : Simple dual-port RAM, registered read, write-before-read.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ldpc_3gpp_enc_acc_ram #(
    parameter int pADDR_W = 8,
    parameter int pDAT_W  = 8
) (
    input  logic              iclk,
    input  logic              iclkena,
    input  logic              iwe,
    input  logic [pADDR_W-1:0] iwaddr,
    input  logic [pDAT_W-1:0]  iwdat,
    input  logic              ire,
    input  logic [pADDR_W-1:0] iraddr,
    output logic [pDAT_W-1:0]  ordat
);

    logic [pDAT_W-1:0] r_mem [2**pADDR_W];

    always_ff @(posedge iclk) begin
        if (iclkena) begin
            if (iwe) begin
                r_mem[iwaddr] <= iwdat;
            end
            if (ire) begin
                ordat <= (iwe && (iwaddr == iraddr)) ? iwdat : r_mem[iraddr];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ldpc_3gpp_enc_p1_acc.sv
// ============================================================================
// Module   : ldpc_3gpp_enc_p1_acc
// Brief    : XOR-accumulates per-row partial products, then drains them to p1.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ldpc_3gpp_enc_p1_acc
    import ldpc_3gpp_enc_p1_acc_pkg::*;
#(
    parameter int pADDR_W  = 8,
    parameter int pDAT_W   = 8,
    parameter int pROW_NUM = cENC_CORE_ROWS
) (
    input  logic               iclk,
    input  logic               ireset,
    input  logic               iclkena,
    input  logic [pADDR_W-3:0] ilen,
    input  logic               ival,
    input  logic               isop,
    input  logic               ieop,
    input  logic [pDAT_W-1:0]  idat,
    output logic               obusy,
    output logic               owrite,
    output logic               owstart,
    output logic [pDAT_W-1:0]  owdat,
    output logic               oerr
);

    localparam int c_ROW_W  = $clog2(pROW_NUM);
    localparam int c_WORD_W = pADDR_W - 2;
    localparam int c_RAM_AW = c_ROW_W + c_WORD_W;
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(pROW_NUM - 1);

    enc_acc_state_t      r_state;
    logic [c_ROW_W-1:0]  r_row, r_drow;
    logic [c_WORD_W-1:0] r_word, r_dword, r_len;
    logic                r_col0, r_flush, r_rd_done, r_rv, r_rfirst;
    logic                r_s1_val, r_s1_ovr;
    logic [c_RAM_AW-1:0] r_s1_addr;
    logic [pDAT_W-1:0]   r_s1_dat;

    logic                w_acc_take, w_restart, w_final, w_col0;
    logic [c_ROW_W-1:0]  w_row;
    logic [c_WORD_W-1:0] w_word, w_len;
    logic                w_drd_first, w_drd_issue, w_dfinal, w_ren;
    logic [c_RAM_AW-1:0] w_raddr;
    logic [pDAT_W-1:0]   w_rdat, w_wdat;

    // isop restarts the position so the word it carries lands at {0,0}
    assign w_acc_take  = ival && ((r_state == c_ACC_ACC) || ((r_state == c_ACC_IDLE) && isop));
    assign w_restart   = (r_state == c_ACC_ACC) && isop;
    assign w_row       = isop ? '0 : r_row;
    assign w_word      = isop ? '0 : r_word;
    assign w_len       = isop ? ilen : r_len;
    assign w_col0      = isop | r_col0;
    assign w_final     = (w_row == c_ROW_LAST) && (w_word == w_len);

    // The first drain read goes out in the second flush cycle, after the last RMW write
    assign w_drd_first = (r_state == c_ACC_FLUSH) && r_flush;
    assign w_drd_issue = w_drd_first || ((r_state == c_ACC_DRAIN) && !r_rd_done);
    assign w_dfinal    = (r_drow == c_ROW_LAST) && (r_dword == r_len);

    assign w_ren   = w_acc_take || w_drd_issue;
    assign w_raddr = w_drd_issue ? {r_drow, r_dword} : {w_row, w_word};
    assign w_wdat  = r_s1_ovr ? r_s1_dat : (w_rdat ^ r_s1_dat);

    ldpc_3gpp_enc_acc_ram #(
        .pADDR_W (c_RAM_AW),
        .pDAT_W  (pDAT_W)
    ) u_ram (
        .iclk    (iclk),
        .iclkena (iclkena),
        .iwe     (r_s1_val),
        .iwaddr  (r_s1_addr),
        .iwdat   (w_wdat),
        .ire     (w_ren),
        .iraddr  (w_raddr),
        .ordat   (w_rdat)
    );

    always_ff @(posedge iclk) begin
        if (!ireset) begin
            r_state   <= c_ACC_IDLE;
            r_row     <= '0;
            r_word    <= '0;
            r_len     <= '0;
            r_col0    <= 1'b0;
            r_flush   <= 1'b0;
            r_drow    <= '0;
            r_dword   <= '0;
            r_rd_done <= 1'b0;
            r_rv      <= 1'b0;
            r_rfirst  <= 1'b0;
            r_s1_val  <= 1'b0;
            r_s1_ovr  <= 1'b0;
            r_s1_addr <= '0;
            r_s1_dat  <= '0;
            obusy     <= 1'b0;
            owrite    <= 1'b0;
            owstart   <= 1'b0;
            owdat     <= '0;
            oerr      <= 1'b0;
        end else if (iclkena) begin
            r_s1_val <= w_acc_take;
            if (w_acc_take) begin
                r_s1_addr <= {w_row, w_word};
                r_s1_dat  <= idat;
                r_s1_ovr  <= w_col0;
            end

            r_rv     <= w_drd_issue;
            r_rfirst <= w_drd_first;
            owrite   <= r_rv;
            owstart  <= r_rv & r_rfirst;
            if (r_rv) begin
                owdat <= w_rdat;
            end

            if (w_drd_issue) begin
                if (w_dfinal) begin
                    r_rd_done <= 1'b1;
                end else if (r_dword == r_len) begin
                    r_dword <= '0;
                    r_drow  <= r_drow + 1'b1;
                end else begin
                    r_dword <= r_dword + 1'b1;
                end
            end

            oerr <= 1'b0;
            if (w_acc_take) begin
                r_len <= w_len;
                if (ieop) begin
                    r_state   <= c_ACC_FLUSH;
                    obusy     <= 1'b1;
                    r_flush   <= 1'b0;
                    r_rd_done <= 1'b0;
                    r_drow    <= '0;
                    r_dword   <= '0;
                    oerr      <= !w_final || w_restart;
                end else begin
                    r_state <= c_ACC_ACC;
                    oerr    <= w_restart;
                    if (w_final) begin
                        r_row  <= '0;
                        r_word <= '0;
                        r_col0 <= 1'b0;
                    end else begin
                        r_col0 <= w_col0;
                        if (w_word == w_len) begin
                            r_row  <= w_row + 1'b1;
                            r_word <= '0;
                        end else begin
                            r_row  <= w_row;
                            r_word <= w_word + 1'b1;
                        end
                    end
                end
            end else if (ival) begin
                oerr <= 1'b1;
            end

            unique case (r_state)
                c_ACC_FLUSH: begin
                    r_flush <= 1'b1;
                    if (r_flush) begin
                        r_state <= c_ACC_DRAIN;
                    end
                end
                c_ACC_DRAIN: begin
                    if (r_rd_done && !r_rv && owrite) begin
                        r_state <= c_ACC_IDLE;
                        obusy   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ldpc_3gpp_enc_p1_acc.sv
// ============================================================================
// Module   : tb_ldpc_3gpp_enc_p1_acc
// Brief    : Directed, table-driven bench for the p1 feeder accumulator.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ldpc_3gpp_enc_p1_acc;

    logic       clk = 1'b0;
    logic       ireset;
    logic       iclkena = 1'b1;
    logic [5:0] ilen;
    logic       ival, isop, ieop;
    logic [7:0] idat;
    logic       obusy, owrite, owstart, oerr;
    logic [7:0] owdat;
    logic       gate = 1'b0;

    ldpc_3gpp_enc_p1_acc #(.pADDR_W(8), .pDAT_W(8), .pROW_NUM(4)) dut (
        .iclk    (clk),
        .ireset  (ireset),
        .iclkena (iclkena),
        .ilen    (ilen),
        .ival    (ival),
        .isop    (isop),
        .ieop    (ieop),
        .idat    (idat),
        .obusy   (obusy),
        .owrite  (owrite),
        .owstart (owstart),
        .owdat   (owdat),
        .oerr    (oerr)
    );

    always #5 clk = ~clk;

    // Clock enable changes well after the edge so it is stable for the next one
    always @(posedge clk) begin
        #2;
        iclkena = gate ? ~iclkena : 1'b1;
    end

    typedef struct {
        int         ncol;
        logic [7:0] d   [3][8];
        logic [7:0] exp [8];
    } vec_t;

    vec_t       tv [4];
    logic [7:0] cur_exp [8];
    int         ncmp = 0;
    int         nfail = 0;

    // Output monitor: one record per enabled, non-reset edge
    logic [7:0] out_dat [$];
    int         out_st  [$];
    int         out_cyc [$];
    int         ecyc = 0;
    int         eop_cyc = 0;
    int         err_cnt = 0;
    logic       m_en, m_eop;

    always begin
        @(posedge clk);
        m_en  = iclkena && ireset;
        m_eop = ival && ieop;
        #1;
        if (m_en) begin
            ecyc++;
            if (m_eop) eop_cyc = ecyc;
            if (owrite) begin
                out_dat.push_back(owdat);
                out_st.push_back(int'(owstart));
                out_cyc.push_back(ecyc);
            end
            if (oerr) err_cnt++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] d, input logic sop, input logic eop);
        @(negedge clk);
        ival = 1'b1; idat = d; isop = sop; ieop = eop;
        @(posedge clk);
        while (!iclkena) @(posedge clk);
    endtask

    task automatic idle_in();
        @(negedge clk);
        ival = 1'b0; isop = 1'b0; ieop = 1'b0; idat = 8'h00;
    endtask

    task automatic wait_done(input int bo);
        int k;
        k = 0;
        @(negedge clk);
        while ((obusy || (out_dat.size() - bo) < 8) && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) begin
            ncmp++;
            nfail++;
            $display("FAIL drain_timeout: got %0d words, expected 8", out_dat.size() - bo);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_frame(input string tag, input int bo, input int be, input int exp_err);
        int n;
        int st;
        n = out_dat.size() - bo;
        check({tag, "_count"}, n, 8);
        check({tag, "_oerr"}, err_cnt - be, exp_err);
        if (n >= 8) begin
            st = 0;
            for (int i = 0; i < 8; i++) begin
                check($sformatf("%s_w%0d", tag, i), int'(out_dat[bo+i]), int'(cur_exp[i]));
                st += out_st[bo+i] << i;
            end
            check({tag, "_owstart"}, st, 1);
            // ieop cycle ends at edge E; the fourth cycle after it begins at edge E+3
            check({tag, "_latency"}, out_cyc[bo] - eop_cyc, 3);
            check({tag, "_contig"}, out_cyc[bo+7] - out_cyc[bo], 7);
        end
    endtask

    task automatic send_vec(input int v, input int junk);
        for (int c = 0; c < tv[v].ncol; c++) begin
            for (int w = 0; w < 8; w++) begin
                drive(tv[v].d[c][w], (c == 0) && (w == 0), (c == tv[v].ncol - 1) && (w == 7));
            end
        end
        for (int j = 0; j < junk; j++) drive(8'hAA, 1'b0, 1'b0);
        idle_in();
    endtask

    task automatic run_vec(input string tag, input int v, input int junk, input int exp_err);
        int bo;
        int be;
        bo = out_dat.size();
        be = err_cnt;
        send_vec(v, junk);
        wait_done(bo);
        cur_exp = tv[v].exp;
        check_frame(tag, bo, be, exp_err);
    endtask

    initial begin
        int bo;
        int be;

        tv[0].ncol = 1;
        tv[0].d[0] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        tv[0].exp  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        tv[1].ncol = 3;
        tv[1].d[0] = '{default: 8'hFF};
        tv[1].d[1] = '{default: 8'h0F};
        tv[1].d[2] = '{default: 8'hF0};
        tv[1].exp  = '{default: 8'h00};
        tv[2].ncol = 2;
        tv[2].d[0] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        tv[2].d[1] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
        tv[2].exp  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        tv[3].ncol = 2;
        tv[3].d[0] = '{default: 8'hAA};
        tv[3].d[1] = '{default: 8'h55};
        tv[3].exp  = '{default: 8'hFF};

        ireset = 1'b0; ilen = 6'd1;
        ival = 1'b0; isop = 1'b0; ieop = 1'b0; idat = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_obusy", int'(obusy), 0);
        check("rst_owrite", int'(owrite), 0);
        check("rst_owstart", int'(owstart), 0);
        check("rst_oerr", int'(oerr), 0);
        check("rst_owdat", int'(owdat), 0);
        @(negedge clk);
        ireset = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 4; v++) run_vec($sformatf("vec%0d", v), v, 0, 0);

        gate = 1'b1;
        run_vec("gated", 1, 0, 0);
        gate = 1'b0;
        repeat (2) @(negedge clk);

        run_vec("drop_in_drain", 0, 5, 5);

        // Early ieop: words 6..7 keep the previous frame's 0x07, 0x08
        cur_exp = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h07, 8'h08};
        bo = out_dat.size();
        be = err_cnt;
        for (int w = 0; w < 6; w++) drive(8'(8'h31 + w), w == 0, w == 5);
        idle_in();
        wait_done(bo);
        check_frame("early_eop", bo, be, 1);

        be = err_cnt;
        drive(8'h12, 1'b0, 1'b0);
        idle_in();
        repeat (3) @(negedge clk);
        check("idle_drop_oerr", err_cnt - be, 1);
        check("idle_drop_obusy", int'(obusy), 0);

        drive(8'h77, 1'b1, 1'b0);
        drive(8'h77, 1'b0, 1'b0);
        drive(8'h77, 1'b0, 1'b0);
        @(negedge clk);
        ival = 1'b0; isop = 1'b0; ireset = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_obusy", int'(obusy), 0);
        check("midrst_owrite", int'(owrite), 0);
        check("midrst_owstart", int'(owstart), 0);
        check("midrst_oerr", int'(oerr), 0);
        check("midrst_owdat", int'(owdat), 0);
        @(negedge clk);
        ireset = 1'b1;
        run_vec("after_rst", 0, 0, 0);

        bo = out_dat.size();
        be = err_cnt;
        drive(8'h55, 1'b1, 1'b0);
        drive(8'h55, 1'b0, 1'b0);
        drive(8'h55, 1'b0, 1'b0);
        send_vec(2, 0);
        wait_done(bo);
        cur_exp = tv[2].exp;
        check_frame("restart", bo, be, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", ncmp, nfail);
        $finish;
    end

endmodule

`default_nettype wire
